axis_frame_buffer: RTL
======================

AXIS_FRAME_BUFFER -- requirements
Module: axis_frame_buffer

Interface
REQ-001 Parameter DATA_W, default 8: width of one stream character in bits.
REQ-002 Parameter DEPTH, default 16: characters per frame; legal range 2 or more.
REQ-003 Parameter PAD, default 0: DATA_W-bit fill value for positions a short frame did not supply.
REQ-004 ACLK  in  1  the only clock; all state changes on the rising edge.
REQ-005 ARESET  in  1  asynchronous, active-high reset.
REQ-006 S_AXIS_TDATA / S_AXIS_TLAST / S_AXIS_TVALID  in  DATA_W/1/1  input character stream.
REQ-007 S_AXIS_TREADY  out  1  input stream ready.
REQ-008 M_AXIS_TDATA / M_AXIS_TLAST / M_AXIS_TVALID  out  DATA_W/1/1  result character stream.
REQ-009 M_AXIS_TREADY  in  1  output stream ready.
REQ-010 in_frame  out  DEPTH*DATA_W  assembled frame to core; element k in bits [k*DATA_W +: DATA_W].
REQ-011 in_valid  out  1  in_frame is complete and waiting for the core.
REQ-012 core_start  in  1  one-cycle pulse; the core has taken in_frame.
REQ-013 core_done  in  1  one-cycle pulse; out_frame is valid this cycle.
REQ-014 out_frame  in  DEPTH*DATA_W  core result, same element packing as in_frame.
REQ-015 busy  out  1  high in every state except LOAD.
REQ-016 err_short / err_long  out  1/1  sticky frame-length error flags.
REQ-017 err_clear  in  1  synchronous clear of both error flags.
REQ-018 frame_cnt  out  16  count of completed output frames; wraps from 65535 to 0.

Function
REQ-019 The FSM shall have states LOAD, DROP, FULL, RUN and SEND.
REQ-020 S_AXIS_TREADY shall equal 1 exactly in LOAD and DROP, decoded from state.
REQ-021 In LOAD, each beat where TVALID and TREADY are both high shall store TDATA at element wr_idx and then increment wr_idx; wr_idx starts at 0.
REQ-022 In LOAD, a beat with TLAST and wr_idx<DEPTH-1 shall fill elements wr_idx+1..DEPTH-1 with PAD, set err_short, and go to FULL.
REQ-023 In LOAD, a beat with wr_idx==DEPTH-1 and TLAST shall go to FULL.
REQ-024 In LOAD, a beat with wr_idx==DEPTH-1 and no TLAST shall go to DROP and set err_long.
REQ-025 DROP shall accept and discard beats, and go to FULL on the beat carrying TLAST.
REQ-026 in_valid shall be high exactly in FULL, rising the cycle after the frame-ending handshake.
REQ-027 In FULL, core_start shall move the FSM to RUN; in all other states core_start shall be ignored.
REQ-028 in_frame shall hold its value from the entry to FULL until the next LOAD write.
REQ-029 In RUN, core_done shall latch out_frame into an internal buffer, set rd_idx=0, and go to SEND; in all other states core_done shall be ignored.
REQ-030 In SEND, M_AXIS_TVALID shall be 1, M_AXIS_TDATA shall equal buffer element rd_idx, and M_AXIS_TLAST shall be 1 exactly when rd_idx==DEPTH-1.
REQ-031 In SEND, each handshake shall increment rd_idx; M_AXIS_TDATA and M_AXIS_TLAST shall stay stable while M_AXIS_TREADY is low.
REQ-032 The handshake with M_AXIS_TLAST high shall increment frame_cnt, clear wr_idx, and return the FSM to LOAD.
REQ-033 Latency: a core_done pulse in cycle t shall give M_AXIS_TVALID high in cycle t+1.
REQ-034 The M_AXIS outputs shall be 0 outside SEND.
REQ-035 Error flags shall stay set until err_clear or reset.
REQ-036 If err_clear and a new error occur in the same cycle, the new error shall win.
REQ-037 wr_idx and rd_idx shall be $clog2(DEPTH) bits wide.

Reset
REQ-038 While ARESET is high, state shall be LOAD, and wr_idx, rd_idx, in_frame, the internal buffer, error flags and frame_cnt shall all be 0.
REQ-039 While ARESET is high, every output shall be 0 except S_AXIS_TREADY, which shall be 1 as decoded from LOAD.
REQ-040 Asserting ARESET in any state, including mid-frame in LOAD or mid-stream in SEND, shall abort the operation immediately; no partial frame shall survive.

Verification (DATA_W=8, DEPTH=4, PAD=8'hFF)
REQ-041 Stream 11,22,33,44 with TLAST on 44 -> in_valid=1 the next cycle, in_frame=32'h44332211, err_short=0, err_long=0.
REQ-042 Full frame, then core_start, then core_done with out_frame=32'hD4C3B2A1 and M_AXIS_TREADY=1 -> output A1,B2,C3,D4 on consecutive cycles, TLAST on D4, frame_cnt=1, busy drops to 0.
REQ-043 Stream 55,66 with TLAST on 66 -> in_frame=32'hFFFF6655, err_short=1; err_clear pulse -> err_short=0.
REQ-044 Stream six beats 01..06 with TLAST on 06 -> in_frame=32'h04030201, beats 05 and 06 accepted and discarded, err_long=1.
REQ-045 During SEND, toggle M_AXIS_TREADY 1,0,0,1 -> TDATA unchanged during the stall cycles, no characters lost or duplicated.
REQ-046 Assert ARESET after two input beats -> all outputs 0, S_AXIS_TREADY=1; a following full frame assembles from element 0.

Source files
------------

// File: rtl/axis_frame_buffer.sv
// Collects an AXI-Stream frame of DEPTH characters for a processing core, then
// streams the core's result back out. Short frames are padded, long frames truncated.
module axis_frame_buffer #(
    parameter int                DATA_W = 8,
    parameter int                DEPTH  = 16,
    parameter logic [DATA_W-1:0] PAD    = '0
) (
    input  logic                      ACLK,
    input  logic                      ARESET,
    input  logic [DATA_W-1:0]         S_AXIS_TDATA,
    input  logic                      S_AXIS_TLAST,
    input  logic                      S_AXIS_TVALID,
    output logic                      S_AXIS_TREADY,
    output logic [DATA_W-1:0]         M_AXIS_TDATA,
    output logic                      M_AXIS_TLAST,
    output logic                      M_AXIS_TVALID,
    input  logic                      M_AXIS_TREADY,
    output logic [DEPTH*DATA_W-1:0]   in_frame,
    output logic                      in_valid,
    input  logic                      core_start,
    input  logic                      core_done,
    input  logic [DEPTH*DATA_W-1:0]   out_frame,
    output logic                      busy,
    output logic                      err_short,
    output logic                      err_long,
    input  logic                      err_clear,
    output logic [15:0]               frame_cnt
);

    localparam int               IDX_W    = $clog2(DEPTH);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH - 1);

    typedef enum logic [2:0] {LOAD, DROP, FULL, RUN, SEND} state_t;

    state_t                  state_q;
    logic [IDX_W-1:0]        wr_idx_q;
    logic [IDX_W-1:0]        rd_idx_q;
    logic [DEPTH*DATA_W-1:0] frame_q;
    logic [DEPTH*DATA_W-1:0] frame_d;
    logic [DEPTH*DATA_W-1:0] buf_q;
    logic                    err_short_q;
    logic                    err_long_q;
    logic [15:0]             frame_cnt_q;
    logic                    in_hs;
    logic                    out_hs;
    logic                    sending;

    assign sending       = (state_q == SEND);
    assign S_AXIS_TREADY = (state_q == LOAD) || (state_q == DROP);
    assign in_hs         = S_AXIS_TVALID && S_AXIS_TREADY;
    assign out_hs        = sending && M_AXIS_TREADY;

    assign M_AXIS_TVALID = sending;
    assign M_AXIS_TDATA  = sending ? buf_q[int'(rd_idx_q)*DATA_W +: DATA_W] : '0;
    assign M_AXIS_TLAST  = sending && (rd_idx_q == LAST_IDX);

    assign in_frame  = frame_q;
    assign in_valid  = (state_q == FULL);
    assign busy      = (state_q != LOAD);
    assign err_short = err_short_q;
    assign err_long  = err_long_q;
    assign frame_cnt = frame_cnt_q;

    // Frame image after the current beat: store at wr_idx, pad the tail if this beat ends the frame early.
    always_comb begin
        frame_d = frame_q;
        for (int k = 0; k < DEPTH; k++) begin
            if (k == int'(wr_idx_q))
                frame_d[k*DATA_W +: DATA_W] = S_AXIS_TDATA;
            else if ((k > int'(wr_idx_q)) && S_AXIS_TLAST)
                frame_d[k*DATA_W +: DATA_W] = PAD;
        end
    end

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            state_q     <= LOAD;
            wr_idx_q    <= '0;
            rd_idx_q    <= '0;
            frame_q     <= '0;
            buf_q       <= '0;
            err_short_q <= 1'b0;
            err_long_q  <= 1'b0;
            frame_cnt_q <= '0;
        end else begin
            // Clear first so an error raised in the same cycle overrides it.
            if (err_clear) begin
                err_short_q <= 1'b0;
                err_long_q  <= 1'b0;
            end
            case (state_q)
                LOAD: begin
                    if (in_hs) begin
                        frame_q  <= frame_d;
                        wr_idx_q <= wr_idx_q + IDX_W'(1);
                        if (wr_idx_q == LAST_IDX) begin
                            if (S_AXIS_TLAST) begin
                                state_q <= FULL;
                            end else begin
                                state_q    <= DROP;
                                err_long_q <= 1'b1;
                            end
                        end else if (S_AXIS_TLAST) begin
                            state_q     <= FULL;
                            err_short_q <= 1'b1;
                        end
                    end
                end
                DROP: begin
                    if (in_hs && S_AXIS_TLAST)
                        state_q <= FULL;
                end
                FULL: begin
                    if (core_start)
                        state_q <= RUN;
                end
                RUN: begin
                    if (core_done) begin
                        buf_q    <= out_frame;
                        rd_idx_q <= '0;
                        state_q  <= SEND;
                    end
                end
                SEND: begin
                    if (out_hs) begin
                        rd_idx_q <= rd_idx_q + IDX_W'(1);
                        if (rd_idx_q == LAST_IDX) begin
                            frame_cnt_q <= frame_cnt_q + 16'd1;
                            wr_idx_q    <= '0;
                            state_q     <= LOAD;
                        end
                    end
                end
                default: state_q <= LOAD;
            endcase
        end
    end

endmodule
